// File: rtl/timer_pkg.sv
// Shared encodings for the timer_ext peripheral: mode values, SFR write
// addresses and control-register bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    TIMER_MODE_0 = 2'd0,
    TIMER_MODE_1 = 2'd1,
    TIMER_MODE_2 = 2'd2,
    TIMER_MODE_3 = 2'd3
  } timer_mode_e;

  localparam logic [1:0] TADDR_COUNT  = 2'd0;
  localparam logic [1:0] TADDR_RELOAD = 2'd1;
  localparam logic [1:0] TADDR_CTRL   = 2'd2;

  localparam int CTRL_GATE = 3;
  localparam int CTRL_CT   = 2;
  localparam int CTRL_M_HI = 1;
  localparam int CTRL_M_LO = 0;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus falling-edge detector for an asynchronous pin.
// All flops reset to 1 so a low pin at reset release is seen as a real edge only.
module edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign o_fall = prev_q & ~sync_q;

endmodule

// File: rtl/timer_ext.sv
// Parametrised 8051-style timer/counter with reload, external count pin and
// optional capture channel (enabled by defining TIMER_EXT_CAPTURE_EN).
module timer_ext
  import timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PRE_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [1:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_tf_clr,
  input  logic             i_cf_clr,
  input  logic             i_tr,
  input  logic             i_int,
  input  logic             i_tx,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_reload,
  output logic [WIDTH-1:0] o_capture,
  output logic [3:0]       o_ctrl,
  output logic             o_tf,
  output logic             o_cf,
  output logic             o_en
);

  localparam int HALF    = WIDTH / 2;
  localparam int CHAIN_W = HALF + PRE_W;
  // Bits between the prescaler and the high counter are frozen in mode 0.
  localparam logic [WIDTH-1:0] MID_MASK =
    ((WIDTH'(1) << HALF) - WIDTH'(1)) & ~((WIDTH'(1) << PRE_W) - WIDTH'(1));

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             tf_q, tf_d;
  logic             tx_fall, cap_mode, tick, ovf;
  logic [CHAIN_W:0] chain_inc;
  logic [WIDTH:0]   full_inc;
  logic [WIDTH-1:0] m0_next;
  timer_mode_e      mode;

  edge_sync u_tx_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_tx),
    .o_fall (tx_fall)
  );

  assign mode = timer_mode_e'(ctrl_q[CTRL_M_HI:CTRL_M_LO]);
  assign o_en = i_rst_n & i_tr & (~ctrl_q[CTRL_GATE] | i_int);

  assign chain_inc = {1'b0, count_q[WIDTH-1:HALF], count_q[PRE_W-1:0]} + (CHAIN_W+1)'(1);
  assign full_inc  = {1'b0, count_q} + (WIDTH+1)'(1);
  assign m0_next   = (count_q & MID_MASK)
                   | {chain_inc[CHAIN_W-1:PRE_W], {HALF{1'b0}}}
                   | WIDTH'(chain_inc[PRE_W-1:0]);

  always_comb begin
    tick = 1'b0;
    if (o_en) begin
      tick = (cap_mode || !ctrl_q[CTRL_CT]) ? 1'b1 : tx_fall;
    end
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    ctrl_d   = ctrl_q;
    ovf      = 1'b0;
    if (tick) begin
      case (mode)
        TIMER_MODE_0: begin
          count_d = m0_next;
          ovf     = chain_inc[CHAIN_W];
        end
        TIMER_MODE_2: begin
          if (&count_q) begin
            count_d = reload_q;
            ovf     = 1'b1;
          end else begin
            count_d = full_inc[WIDTH-1:0];
          end
        end
        default: begin
          count_d = full_inc[WIDTH-1:0];
          ovf     = full_inc[WIDTH];
        end
      endcase
    end
    if (i_wr) begin
      case (i_waddr)
        TADDR_COUNT: begin
          count_d = i_wdata;
          ovf     = 1'b0;
        end
        TADDR_RELOAD: reload_d = i_wdata;
        TADDR_CTRL:   ctrl_d   = i_wdata[3:0];
        default: ;
      endcase
    end
    tf_d = ovf | (tf_q & ~i_tf_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      reload_q <= '0;
      ctrl_q   <= '0;
      tf_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      ctrl_q   <= ctrl_d;
      tf_q     <= tf_d;
    end
  end

`ifdef TIMER_EXT_CAPTURE_EN
  logic [WIDTH-1:0] capture_q, capture_d;
  logic             cf_q, cf_d;

  assign cap_mode  = (mode == TIMER_MODE_3);
  // Capture follows the pin even while the timer is stopped.
  assign capture_d = (cap_mode && tx_fall) ? count_q : capture_q;
  assign cf_d      = (cap_mode & tx_fall) | (cf_q & ~i_cf_clr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      capture_q <= '0;
      cf_q      <= 1'b0;
    end else begin
      capture_q <= capture_d;
      cf_q      <= cf_d;
    end
  end

  assign o_capture = capture_q;
  assign o_cf      = cf_q;
`else
  logic unused_cf_clr;

  assign unused_cf_clr = i_cf_clr;
  assign cap_mode      = 1'b0;
  assign o_capture     = '0;
  assign o_cf          = 1'b0;
`endif

  assign o_count  = count_q;
  assign o_reload = reload_q;
  assign o_ctrl   = ctrl_q;
  assign o_tf     = tf_q;

endmodule

// File: tb/tb_timer_ext.sv
// Randomised and directed bench for timer_ext: a behavioural model predicts
// every cycle's outputs into a queue that an independent monitor drains.
module tb_timer_ext;

  localparam int WIDTH = 16;
  localparam int PRE_W = 5;
  localparam int HALF  = WIDTH / 2;
  localparam logic [1:0] A_COUNT  = 2'd0;
  localparam logic [1:0] A_RELOAD = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
`ifdef TIMER_EXT_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] rel;
    logic [15:0] cap;
    logic [3:0]  ctl;
    logic        tf;
    logic        cf;
    logic        en;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  waddr = 2'd0;
  logic [15:0] wdata = 16'd0;
  logic        tf_clr = 1'b0, cf_clr = 1'b0, tr = 1'b0, gate_in = 1'b0, tx = 1'b1;
  logic [15:0] o_count, o_reload, o_capture;
  logic [3:0]  o_ctrl;
  logic        o_tf, o_cf, o_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Held (level) inputs applied by every step
  bit h_tr = 1'b0, h_int = 1'b0, h_tx = 1'b1;

  // Reference model state
  logic [15:0] m_count, m_reload, m_cap;
  logic [3:0]  m_ctrl;
  bit          m_tf, m_cf;
  bit          hist[$];
  exp_t        sb[$];

  timer_ext #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wr     (wr),
    .i_waddr  (waddr),
    .i_wdata  (wdata),
    .i_tf_clr (tf_clr),
    .i_cf_clr (cf_clr),
    .i_tr     (tr),
    .i_int    (gate_in),
    .i_tx     (tx),
    .o_count  (o_count),
    .o_reload (o_reload),
    .o_capture(o_capture),
    .o_ctrl   (o_ctrl),
    .o_tf     (o_tf),
    .o_cf     (o_cf),
    .o_en     (o_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_count = '0; m_reload = '0; m_cap = '0; m_ctrl = '0; m_tf = 0; m_cf = 0;
    hist = {1'b1, 1'b1, 1'b1, 1'b1};
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = '{default: '0};
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0; wr = 1'b0; tf_clr = 1'b0; cf_clr = 1'b0;
      tr = h_tr; gate_in = h_int; tx = h_tx;
      sb.push_back(e);
    end
  endtask

  // One clock: drive inputs, advance the model by the spec rules, queue prediction.
  task automatic step(input bit w, input logic [1:0] a, input logic [15:0] d,
                      input bit tfc, input bit cfc);
    exp_t e;
    bit fall, en, capm, tick, ovf;
    int mode, c, chain, mid, nc;
    @(negedge clk);
    rst_n = 1'b1; wr = w; waddr = a; wdata = d; tf_clr = tfc; cf_clr = cfc;
    tr = h_tr; gate_in = h_int; tx = h_tx;

    // A pin fall takes effect at the third rising edge after it happens.
    hist.push_back(h_tx);
    if (hist.size() > 8) void'(hist.pop_front());
    fall = hist[hist.size()-4] && !hist[hist.size()-3];

    mode = int'(m_ctrl[1:0]);
    c    = int'(m_count);
    en   = h_tr && (!m_ctrl[3] || h_int);
    capm = CAP && (mode == 3);
    tick = en && (capm || !m_ctrl[2] || fall);
    nc   = c;
    ovf  = 0;
    if (tick) begin
      if (mode == 0) begin
        chain = (c >> HALF) * (1 << PRE_W) + (c % (1 << PRE_W)) + 1;
        mid   = c & ((1 << HALF) - 1) & ~((1 << PRE_W) - 1);
        if (chain == (1 << (HALF + PRE_W))) begin ovf = 1; chain = 0; end
        nc = ((chain >> PRE_W) << HALF) + mid + (chain % (1 << PRE_W));
      end else if (c == 65535) begin
        ovf = 1;
        nc  = (mode == 2) ? int'(m_reload) : 0;
      end else begin
        nc = c + 1;
      end
    end
    if (w && a == A_COUNT) begin nc = int'(d); ovf = 0; end
    if (capm && fall) begin m_cap = m_count; m_cf = 1; end
    else if (cfc) m_cf = 0;
    if (ovf) m_tf = 1;
    else if (tfc) m_tf = 0;
    if (w && a == A_RELOAD) m_reload = d;
    if (w && a == A_CTRL) m_ctrl = d[3:0];
    m_count = 16'(nc);

    e.cnt = m_count; e.rel = m_reload; e.cap = m_cap; e.ctl = m_ctrl;
    e.tf = m_tf; e.cf = m_cf;
    e.en = h_tr && (!m_ctrl[3] || h_int);
    sb.push_back(e);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic wreg(input logic [1:0] a, input logic [15:0] d);
    step(1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count",   32'(o_count),   32'(e.cnt));
        chk("reload",  32'(o_reload),  32'(e.rel));
        chk("capture", 32'(o_capture), 32'(e.cap));
        chk("ctrl",    32'(o_ctrl),    32'(e.ctl));
        chk("tf",      32'(o_tf),      32'(e.tf));
        chk("cf",      32'(o_cf),      32'(e.cf));
        chk("en",      32'(o_en),      32'(e.en));
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int hold;
    h_tr = 1'b1;
    do_reset(3);

    // Mode 1 free run through wrap
    h_tr = 0; wreg(A_CTRL, 16'h0001); wreg(A_COUNT, 16'hFFFE);
    h_tr = 1; cyc(2);
    at_edge();
    chk("m1_wrap_count", 32'(o_count), 32'h0000);
    chk("m1_wrap_tf", 32'(o_tf), 32'h1);
    cyc(3); step(0, 2'd0, 16'd0, 1'b1, 1'b0); h_tr = 0; cyc(2);

    // Mode 2 auto-reload, clear coinciding with re-set
    wreg(A_CTRL, 16'h0002); wreg(A_RELOAD, 16'hFF00); wreg(A_COUNT, 16'hFFFF);
    h_tr = 1; cyc(1);
    step(0, 2'd0, 16'd0, 1'b1, 1'b0);
    cyc(254);
    step(0, 2'd0, 16'd0, 1'b1, 1'b0);
    cyc(2); h_tr = 0;

    // Mode 0 prescaled chain
    wreg(A_CTRL, 16'h0000); step(0, 2'd0, 16'd0, 1'b1, 1'b0);
    wreg(A_COUNT, 16'h001F); h_tr = 1; cyc(1); h_tr = 0;
    at_edge();
    chk("m0_carry_count", 32'(o_count), 32'h0100);
    wreg(A_COUNT, 16'hFFBF); h_tr = 1; cyc(1); h_tr = 0;
    at_edge();
    chk("m0_wrap_count", 32'(o_count), 32'h00A0);
    chk("m0_wrap_tf", 32'(o_tf), 32'h1);
    cyc(2);

    // Gate
    wreg(A_CTRL, 16'h0009); h_tr = 1; h_int = 0; cyc(3);
    h_int = 1; cyc(3); h_int = 0; h_tr = 0; cyc(1);

    // Counter mode on the pin, then write colliding with an increment
    wreg(A_CTRL, 16'h0005); wreg(A_COUNT, 16'h0000); h_tr = 1;
    for (int p = 0; p < 5; p++) begin
      h_tx = 0; cyc(4); h_tx = 1; cyc(4);
    end
    at_edge();
    chk("ct1_five_edges", 32'(o_count), 32'h0005);
    h_tx = 0; cyc(2); wreg(A_COUNT, 16'h1234);
    at_edge();
    chk("ct1_write_wins", 32'(o_count), 32'h1234);
    cyc(2); h_tx = 1; cyc(4);

    // Capture mode
    h_tr = 0; step(0, 2'd0, 16'd0, 1'b1, 1'b1);
    wreg(A_CTRL, 16'h0003); wreg(A_COUNT, 16'h003C);
    h_tr = 1; cyc(4);
    h_tx = 0; cyc(3);
    at_edge();
    chk("capture_value", 32'(o_capture), CAP ? 32'h0042 : 32'h0000);
    chk("capture_flag", 32'(o_cf), CAP ? 32'h1 : 32'h0);
    cyc(2); h_tx = 1; cyc(3);
    step(0, 2'd0, 16'd0, 1'b0, 1'b1);
    h_tr = 0; h_tx = 0; cyc(4); h_tx = 1; cyc(4);

    // Reset in the middle of a run
    wreg(A_CTRL, 16'h0001); h_tr = 1; cyc(5);
    do_reset(2);
    cyc(4);

    // Randomised traffic
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      bit w, tfc, cfc;
      logic [1:0] a;
      logic [15:0] d;
      w   = ($urandom_range(0, 11) == 0);
      a   = 2'($urandom_range(0, 3));
      d   = ($urandom_range(0, 1) == 1) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                        : 16'($urandom);
      tfc = ($urandom_range(0, 7) == 0);
      cfc = ($urandom_range(0, 7) == 0);
      h_tr  = ($urandom_range(0, 7) != 0);
      h_int = ($urandom_range(0, 1) == 1);
      if (hold == 0) begin
        h_tx = ~h_tx;
        hold = $urandom_range(2, 5);
      end
      hold--;
      step(w, a, d, tfc, cfc);
    end

    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
